outreg_bank: RTL
================

# outreg_bank

Parametrised AP3 IO output register bank that generalises the single output register cell. It provides WIDTH channels, each with a per-channel combinational bypass, and a shared programmable delay line of 1..DEPTH stages gated by a clock enable. A retap-hold FSM keeps the pad side glitch-free while the delay line refills after a tap change. It sits between fabric output data (OQI) and the pad-facing F2A drive.

## Interface
- WIDTH, 8, number of output channels (≥1)
- DEPTH, 4, maximum delay-line stages (≥1)
- TAPW, $clog2(DEPTH+1), derived width of TAP and the hold counter; not overridden
- IQC  input  1  clock, rising edge
- QRT  input  1  reset, asynchronous, active-high
- CE  input  1  clock enable for delay-line shift and hold counting
- OSEL  input  WIDTH  per-channel bypass; 1 = F2A[i] driven combinationally from OQI[i]
- OQI  input  WIDTH  fabric output data
- TAP  input  TAPW  requested delay in CE edges; 0 is treated as 1, values >DEPTH are clamped to DEPTH (tap_eff)
- F2A  output  WIDTH  pad-side output
- BUSY  output  1  high while the retap hold is active

## Operation
- Delay line s[0..DEPTH-1], each WIDTH bits wide. On each IQC edge with CE=1: s[0]<=OQI and s[k]<=s[k-1]. With CE=0 the line holds.
- Registered path: rq = s[tap_q-1], where tap_q is a registered copy of the active tap.
- Output: F2A[i] = OSEL[i] ? OQI[i] : (state==HOLD ? hold_q[i] : rq[i]). OSEL is never registered and takes effect immediately.
- FSM states:
  - RUN
    - Each edge compares tap_eff with tap_q, independent of CE.
    - On mismatch: hold_q<=rq (the value presented just before the edge), tap_q<=tap_eff, cnt<=tap_eff, next state HOLD.
  - HOLD
    - Each edge with CE=1 decrements cnt.
    - On an edge with CE=1 and cnt==1: next state RUN.
    - A new mismatch while in HOLD restarts the hold: tap_q<=tap_eff, cnt<=tap_eff, hold_q unchanged.
    - CE=0 freezes cnt.
- The delay line keeps shifting normally during HOLD. The retap edge itself shifts the line if CE=1 but does not count toward cnt.
- BUSY = (state==HOLD), registered.
- Reset (QRT=1, asynchronous): all s, hold_q, and cnt = 0; tap_q=1; state RUN; BUSY=0. The registered component of F2A is therefore 0. Reset mid-HOLD aborts the hold immediately.
- Arithmetic: cnt is TAPW bits and never wraps; it is loaded only with 1..DEPTH and decremented only when ≥1.

## Timing
- Bypass path (OSEL=1): zero-cycle combinational from OQI to F2A.
- Registered path: OQI sampled at a CE edge appears on F2A after exactly tap_q CE edges. For tap 1, it is visible right after the capturing edge.
- Retap: F2A shows hold_q from the edge that detects the mismatch until the edge that exits HOLD.
  - HOLD lasts tap_eff CE edges after the retap edge; BUSY is high for that same span.
  - From the exit edge onward, F2A = s[tap_q-1], which contains data captured entirely after the retap.
- TAP change and CE=0 together: HOLD is entered, and it persists until tap_eff CE edges occur.
- If TAP changes back to the old value during HOLD, that is still a mismatch against the new tap_q, so the hold restarts.
- All registers share IQC. QRT deassertion must meet recovery timing to IQC.

## Configuration
- OUTREG_BANK_HOLD_EN defined: the retap-hold FSM, hold_q, cnt, and BUSY behave as described above.
- OUTREG_BANK_HOLD_EN undefined:
  - FSM, hold_q, and cnt are removed, and BUSY is tied to 0.
  - tap_q still updates one edge after a TAP change; the registered path then immediately selects s[tap_q-1], which may expose stale stage contents.

## Test plan
- Reset: assert QRT with OQI=8'hFF, OSEL=0, TAP=2, mid-clock → F2A=8'h00 and BUSY=0 asynchronously; s and hold_q stay 0 after release.
- Latency: TAP=3 steady, OSEL=0, CE=1, OQI sequence 8'h01,02,03,… per edge → F2A shows 8'h01 right after the 3rd edge, then increments each edge.
- CE gating: TAP=2, CE toggling 1,0,1,0 → F2A advances only on CE=1 edges; latency is measured in CE edges.
- Bypass mix: OSEL=8'h0F, OQI changed between edges → the low nibble follows OQI combinationally; the high nibble follows the delay line.
- Retap hold: F2A=8'hA5 in steady state at TAP=1, then TAP=4 → F2A holds 8'hA5 and BUSY=1 for 4 CE edges, then outputs data captured after the retap. Changing TAP to 2 mid-hold restarts the hold for 2 CE edges.
- Without OUTREG_BANK_HOLD_EN: same retap stimulus → BUSY stays 0 and F2A switches to s[3] one edge after the TAP change.

Source files
------------

// File: rtl/outreg_bank_if.sv
// Signal bundle for the outreg_bank output register bank.
// Carries fabric data, bypass/tap control, the pad-side drive and hold status.
interface outreg_bank_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int TAPW = $clog2(DEPTH + 1);

    logic             CE;
    logic [WIDTH-1:0] OSEL;
    logic [WIDTH-1:0] OQI;
    logic [TAPW-1:0]  TAP;
    logic [WIDTH-1:0] F2A;
    logic             BUSY;

    modport master (output CE, OSEL, OQI, TAP, input F2A, BUSY);
    modport slave  (input CE, OSEL, OQI, TAP, output F2A, BUSY);
endinterface

// File: rtl/outreg_bank.sv
// WIDTH-channel output register bank: per-channel bypass plus a shared 1..DEPTH tap delay line.
// Define OUTREG_BANK_HOLD_EN to enable the glitch-free retap-hold FSM (BUSY tied low otherwise).
module outreg_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic          IQC,
    input logic          QRT,
    outreg_bank_if.slave bus
);
    localparam int TAPW = $clog2(DEPTH + 1);

    logic [TAPW-1:0]  tap_eff;
    logic [TAPW-1:0]  tap_q;
    logic [WIDTH-1:0] s [DEPTH];
    logic [WIDTH-1:0] rq;
    logic [WIDTH-1:0] reg_out;

    // Requested tap of 0 behaves as 1; anything past the line length uses the last stage.
    always_comb begin
        tap_eff = bus.TAP;
        if (bus.TAP == '0) begin
            tap_eff = TAPW'(1);
        end else if (bus.TAP > TAPW'(DEPTH)) begin
            tap_eff = TAPW'(DEPTH);
        end
    end

    always_ff @(posedge IQC or posedge QRT) begin
        if (QRT) begin
            for (int k = 0; k < DEPTH; k++) begin
                s[k] <= '0;
            end
        end else if (bus.CE) begin
            s[0] <= bus.OQI;
            for (int k = 1; k < DEPTH; k++) begin
                s[k] <= s[k-1];
            end
        end
    end

    always_comb begin
        rq = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap_q == TAPW'(k + 1)) begin
                rq = s[k];
            end
        end
    end

`ifdef OUTREG_BANK_HOLD_EN
    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic [TAPW-1:0]  cnt;
    logic [WIDTH-1:0] hold_q;
    logic             busy_q;

    // A tap change freezes the pad value until the line has refilled with post-retap data;
    // a further change mid-hold restarts the count but keeps the originally frozen value.
    always_ff @(posedge IQC or posedge QRT) begin
        if (QRT) begin
            state  <= RUN;
            tap_q  <= TAPW'(1);
            cnt    <= '0;
            hold_q <= '0;
            busy_q <= 1'b0;
        end else if (tap_eff != tap_q) begin
            if (state == RUN) begin
                hold_q <= rq;
            end
            tap_q  <= tap_eff;
            cnt    <= tap_eff;
            state  <= HOLD;
            busy_q <= 1'b1;
        end else if (state == HOLD && bus.CE && cnt != '0) begin
            cnt <= cnt - TAPW'(1);
            if (cnt == TAPW'(1)) begin
                state  <= RUN;
                busy_q <= 1'b0;
            end
        end
    end

    assign reg_out  = (state == HOLD) ? hold_q : rq;
    assign bus.BUSY = busy_q;
`else
    always_ff @(posedge IQC or posedge QRT) begin
        if (QRT) begin
            tap_q <= TAPW'(1);
        end else begin
            tap_q <= tap_eff;
        end
    end

    assign reg_out  = rq;
    assign bus.BUSY = 1'b0;
`endif

    assign bus.F2A = (bus.OSEL & bus.OQI) | (~bus.OSEL & reg_out);

endmodule
